// File: rtl/music_if.sv
// Control/status bundle between the game FSM and the note sequencer.
// The master drives transport controls; the slave returns note and position.
interface music_if #(
  parameter int NOTE_W = 5,
  parameter int CNT_W  = 32
);
  logic              start;
  logic              stop;
  logic              pause;
  logic              loop_en;
  logic [1:0]        mode;
  logic [NOTE_W-1:0] note;
  logic [CNT_W-1:0]  beat_cnt;
  logic              beat_tick;
  logic              playing;
  logic              done;

  modport master (
    output start, stop, pause, loop_en, mode,
    input  note, beat_cnt, beat_tick, playing, done
  );

  modport slave (
    input  start, stop, pause, loop_en, mode,
    output note, beat_cnt, beat_tick, playing, done
  );
endinterface

// File: rtl/music_sequencer.sv
// Self-timed note sequencer: divides clk into beats and plays one of
// four latched patterns with start/stop/pause, loop and end-of-tune flag.
module music_sequencer #(
  parameter int NOTE_W    = 5,
  parameter int CNT_W     = 32,
  parameter int BEAT_DIV  = 12_500_000,
  parameter int NUM_BEATS = 64
) (
  input  logic     clk,
  input  logic     rst,
  music_if.slave   bus
);
  typedef enum logic [1:0] {
    IDLE, PLAY, PAUSE, DONE
  } state_t;

  localparam logic [CNT_W-1:0] DIV_LAST  =
    CNT_W'(BEAT_DIV - 1);
  localparam logic [CNT_W-1:0] BEAT_LAST =
    CNT_W'(NUM_BEATS - 1);

  localparam logic [NOTE_W-1:0] N_S  = NOTE_W'(0);
  localparam logic [NOTE_W-1:0] N_F4 = NOTE_W'(4);
  localparam logic [NOTE_W-1:0] N_A4 = NOTE_W'(6);
  localparam logic [NOTE_W-1:0] N_C5 = NOTE_W'(8);

  state_t           state, state_n;
  logic [CNT_W-1:0] div_cnt, div_n;
  logic [CNT_W-1:0] beat_q, beat_n;
  logic [1:0]       mode_q, mode_n;
  logic             tick_q, tick_n;
  logic [NOTE_W-1:0] note_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      div_cnt <= '0;
      beat_q  <= '0;
      mode_q  <= 2'd0;
      tick_q  <= 1'b0;
    end else begin
      state   <= state_n;
      div_cnt <= div_n;
      beat_q  <= beat_n;
      mode_q  <= mode_n;
      tick_q  <= tick_n;
    end
  end

  // The release cycle of pause already counts as a play cycle.
  always_comb begin
    state_n = state;
    div_n   = div_cnt;
    beat_n  = beat_q;
    mode_n  = mode_q;
    tick_n  = 1'b0;
    if (bus.stop) begin
      state_n = IDLE;
      div_n   = '0;
      beat_n  = '0;
    end else if (bus.start) begin
      state_n = PLAY;
      div_n   = '0;
      beat_n  = '0;
      mode_n  = bus.mode;
    end else if (state == PLAY || state == PAUSE) begin
      if (bus.pause) begin
        state_n = PAUSE;
      end else begin
        state_n = PLAY;
        if (div_cnt == DIV_LAST) begin
          div_n = '0;
          if (beat_q != BEAT_LAST) begin
            beat_n = beat_q + 1'b1;
            tick_n = 1'b1;
          end else if (bus.loop_en) begin
            beat_n = '0;
            tick_n = 1'b1;
          end else begin
            state_n = DONE;
          end
        end else begin
          div_n = div_cnt + 1'b1;
        end
      end
    end
  end

  always_comb begin
    note_c = N_S;
    if (state == PLAY) begin
      unique case (mode_q)
        2'd0: note_c = (beat_q == '0) ? N_S :
                       beat_q[0] ? N_A4 : N_F4;
        2'd1: note_c = beat_q[0] ? N_S : N_C5;
        2'd2: note_c = NOTE_W'(beat_q[2:0]) +
                       NOTE_W'(1);
        2'd3: note_c = N_S;
      endcase
    end
  end

  assign bus.note      = note_c;
  assign bus.beat_cnt  = beat_q;
  assign bus.beat_tick = tick_q;
  assign bus.playing   = (state == PLAY) ||
                         (state == PAUSE);
  assign bus.done      = (state == DONE);
endmodule
